// File: rtl/alarm_ringer.sv
// Alarm ring/snooze/auto-off controller: edge-detects alarm == time and drives
// the buzzer waveform plus ring/snooze status toward display and speaker.
module alarm_ringer #(
  parameter int SNOOZE_MIN = 9,
  parameter int RING_MIN   = 10,
  parameter int MAX_SNOOZE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] timeData,
  input  logic [15:0] alarmData,
  input  logic        alarmEn,
  input  logic        minTick,
  input  logic        secTick,
  input  logic        snoozeBtn,
  input  logic        stopBtn,
  output logic        ring,
  output logic        snoozing,
  output logic        buzzer,
  output logic [7:0]  snoozesLeft
);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  state_t     state, state_nxt;
  logic       buzzer_nxt;
  logic [7:0] snz_left_nxt;
  logic [7:0] ringCnt, ring_cnt_nxt;
  logic [7:0] snzCnt, snz_cnt_nxt;
  logic       match, matchPrev, trigger;

  assign match   = (timeData == alarmData);
  assign trigger = match & ~matchPrev & alarmEn;

  assign ring     = (state == RINGING);
  assign snoozing = (state == SNOOZE);

  // matchPrev resets high so a time already at the alarm does not fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      buzzer      <= 1'b0;
      snoozesLeft <= 8'(MAX_SNOOZE);
      ringCnt     <= '0;
      snzCnt      <= '0;
      matchPrev   <= 1'b1;
    end else begin
      state       <= state_nxt;
      buzzer      <= buzzer_nxt;
      snoozesLeft <= snz_left_nxt;
      ringCnt     <= ring_cnt_nxt;
      snzCnt      <= snz_cnt_nxt;
      matchPrev   <= match;
    end
  end

  always_comb begin
    state_nxt    = state;
    buzzer_nxt   = 1'b0;
    snz_left_nxt = snoozesLeft;
    ring_cnt_nxt = ringCnt;
    snz_cnt_nxt  = snzCnt;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          state_nxt    = RINGING;
          ring_cnt_nxt = '0;
          snz_left_nxt = 8'(MAX_SNOOZE);
          buzzer_nxt   = 1'b1;
        end
      end
      RINGING: begin
        buzzer_nxt = buzzer ^ secTick;
        if (!alarmEn || stopBtn) begin
          state_nxt  = IDLE;
          buzzer_nxt = 1'b0;
        end else if (snoozeBtn && snoozesLeft != 8'd0) begin
          state_nxt    = SNOOZE;
          snz_cnt_nxt  = 8'(SNOOZE_MIN);
          snz_left_nxt = snoozesLeft - 8'd1;
          buzzer_nxt   = 1'b0;
        end else if (minTick) begin
          // An exhausted snooze press falls through so the timeout still runs.
          if (ringCnt == 8'(RING_MIN - 1)) begin
            state_nxt  = IDLE;
            buzzer_nxt = 1'b0;
          end else begin
            ring_cnt_nxt = ringCnt + 8'd1;
          end
        end
      end
      SNOOZE: begin
        if (!alarmEn || stopBtn) begin
          state_nxt = IDLE;
        end else if (minTick) begin
          if (snzCnt == 8'd1) begin
            state_nxt    = RINGING;
            ring_cnt_nxt = '0;
            buzzer_nxt   = 1'b1;
          end else begin
            snz_cnt_nxt = snzCnt - 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer with SNOOZE_MIN=5, RING_MIN=3, MAX_SNOOZE=2.
module tb_alarm_ringer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] timeData, alarmData;
  logic        alarmEn, minTick, secTick, snoozeBtn, stopBtn;
  logic        ring, snoozing, buzzer;
  logic [7:0]  snoozesLeft;
  int          checks = 0;
  int          failures = 0;

  alarm_ringer #(.SNOOZE_MIN(5), .RING_MIN(3), .MAX_SNOOZE(2)) dut (
    .clk(clk), .rst_n(rst_n), .timeData(timeData), .alarmData(alarmData),
    .alarmEn(alarmEn), .minTick(minTick), .secTick(secTick),
    .snoozeBtn(snoozeBtn), .stopBtn(stopBtn), .ring(ring),
    .snoozing(snoozing), .buzzer(buzzer), .snoozesLeft(snoozesLeft)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs: {ring, snoozing, buzzer, snoozesLeft}
  task automatic check_out(input string tag, input logic r, input logic s,
                           input logic b, input logic [7:0] left);
    check(tag, {5'd0, ring, snoozing, buzzer, snoozesLeft}, {5'd0, r, s, b, left});
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic min_ticks(input int n);
    repeat (n) begin
      minTick = 1'b1; cyc(); minTick = 1'b0;
    end
  endtask

  task automatic snooze();
    snoozeBtn = 1'b1; cyc(); snoozeBtn = 1'b0;
  endtask

  // Leave the alarm minute and come back so a fresh match edge fires.
  task automatic retrigger();
    timeData = 16'h0731; cyc();
    timeData = 16'h0730; cyc();
  endtask

  initial begin
    rst_n = 1'b0; timeData = 16'h0729; alarmData = 16'h0730; alarmEn = 1'b1;
    minTick = 0; secTick = 0; snoozeBtn = 0; stopBtn = 0;
    #12;
    check_out("reset", 0, 0, 0, 8'd2);
    rst_n = 1'b1;
    cyc();

    // Trigger latency and buzzer toggling
    timeData = 16'h0730;
    check_out("pre_edge", 0, 0, 0, 8'd2);
    cyc();
    check_out("trigger", 1, 0, 1, 8'd2);
    secTick = 1; cyc(); secTick = 0;
    check("buz_tog1", {15'd0, buzzer}, 16'd0);
    cyc();
    check("buz_hold", {15'd0, buzzer}, 16'd0);
    secTick = 1; cyc(); secTick = 0;
    check("buz_tog2", {15'd0, buzzer}, 16'd1);

    // Snooze then re-ring after exactly 5 minTicks
    snooze();
    check_out("snooze1", 0, 1, 0, 8'd1);
    min_ticks(4);
    check_out("snooze_4min", 0, 1, 0, 8'd1);
    min_ticks(1);
    check_out("rering1", 1, 0, 1, 8'd1);

    // Use last snooze, then an exhausted snooze is ignored
    snooze();
    check_out("snooze2", 0, 1, 0, 8'd0);
    min_ticks(5);
    check_out("rering2", 1, 0, 1, 8'd0);
    snooze();
    check_out("snooze_exhausted", 1, 0, 1, 8'd0);

    // Auto-off after 3 minTicks, no retrigger while time stays at alarm
    min_ticks(2);
    check("timeout_2min", {15'd0, ring}, 16'd1);
    min_ticks(1);
    check_out("timeout", 0, 0, 0, 8'd0);
    cyc(3);
    check("no_retrigger", {15'd0, ring}, 16'd0);

    // Stop and snooze together: stop wins, no decrement
    retrigger();
    check_out("retrigger", 1, 0, 1, 8'd2);
    stopBtn = 1; snoozeBtn = 1; cyc(); stopBtn = 0; snoozeBtn = 0;
    check_out("stop_wins", 0, 0, 0, 8'd2);

    // alarmEn dropped during snooze returns to idle; re-arm gives no edge
    retrigger();
    snooze();
    check_out("snooze3", 0, 1, 0, 8'd1);
    alarmEn = 0; cyc();
    check_out("disable_snz", 0, 0, 0, 8'd1);
    alarmEn = 1; cyc(2);
    check("rearm_no_ring", {15'd0, ring}, 16'd0);

    // Disabled alarm ignores a match edge
    alarmEn = 0; retrigger();
    check("disabled_edge", {15'd0, ring}, 16'd0);
    alarmEn = 1;

    // Trigger and stop in the same idle cycle: trigger taken
    timeData = 16'h0731; cyc();
    timeData = 16'h0730; stopBtn = 1; cyc(); stopBtn = 0;
    check_out("trig_with_stop", 1, 0, 1, 8'd2);

    // Reset mid-ringing with time == alarm
    snooze(); min_ticks(5);
    check_out("pre_reset", 1, 0, 1, 8'd1);
    rst_n = 0; #1;
    check_out("async_reset", 0, 0, 0, 8'd2);
    cyc(); rst_n = 1; cyc(3);
    check_out("post_reset", 0, 0, 0, 8'd2);
    retrigger();
    check_out("post_reset_trig", 1, 0, 1, 8'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
